// File: rtl/brew_pkg.sv
// brew_pkg: shared definitions for the brew sequencer and its display decode.
//   - brew_state_t : 3-bit state code (IDLE=0, HEAT=1, PUMP=2, DRIP=3, SLEEP=4)
//   - STATE_W      : width of the state code
//   - CUP_W        : width of the reservoir cup count
//   - TIMER_W      : width of the phase timer (phases last 1..15 ticks)
//   - IDLE_W       : width of the optional idle-to-sleep counter
//   - is_busy()    : true for the three brewing phases
package brew_pkg;

  localparam int STATE_W = 3;
  localparam int CUP_W   = 2;
  localparam int TIMER_W = 4;
  localparam int IDLE_W  = 6;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 3'd0,
    HEAT  = 3'd1,
    PUMP  = 3'd2,
    DRIP  = 3'd3,
    SLEEP = 3'd4
  } brew_state_t;

  function automatic logic is_busy(input brew_state_t s);
    return (s == HEAT) || (s == PUMP) || (s == DRIP);
  endfunction

endpackage

// File: rtl/phase_timer.sv
// phase_timer: tick counter shared by the HEAT, PUMP and DRIP phases.
//   clk, rst_n : system clock, asynchronous active-low reset
//   clear      : forces the count to zero (asserted on phase entry and outside phases)
//   tick       : single-cycle 1 Hz enable; the count advances only on these cycles
//   target     : phase length in ticks (1..15)
//   done       : combinational; high on the tick that brings the count to target
module phase_timer
  import brew_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               tick,
  input  logic [TIMER_W-1:0] target,
  output logic               done
);

  logic [TIMER_W-1:0] count;

  // done is not gated by clear: clear is derived from the next state, which
  // itself depends on done, so gating here would close a combinational loop.
  assign done = tick && (count == (target - TIMER_W'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (tick) begin
      count <= count + TIMER_W'(1);
    end
  end

endmodule

// File: rtl/brew_sequencer.sv
// brew_sequencer: sequences one brew cycle HEAT -> PUMP -> DRIP, drives the
// heater and pump enables and tracks the reservoir cup count.
//   clk_100MHz : system clock
//   reset_n    : asynchronous active-low reset (aborts a cycle, empties cup count)
//   tick_1Hz   : single-cycle enable, once per second
//   brew_btn   : debounced make-coffee level
//   fill_btn   : debounced fill-water level
//   heater_on  : heater enable (HEAT and PUMP)
//   pump_on    : pump enable (PUMP)
//   state      : current state code, also the FSM debug view
//   cup_count  : cups of water remaining
//   busy       : high in HEAT, PUMP or DRIP
//   err_empty  : one-cycle pulse when a brew is refused on an empty reservoir
// Build option: define IDLE_SLEEP_EN to add the idle-to-SLEEP timeout.
//
// Interface contract: there is no valid/ready handshake. Buttons are levels;
// a request is the registered rising edge of a level, so a held button makes
// exactly one request. tick_1Hz is a one-cycle enable and is never stretched.
// All outputs are registered, computed from the next state.
module brew_sequencer
  import brew_pkg::*;
#(
  parameter int HEAT_SECS  = 3,
  parameter int PUMP_SECS  = 5,
  parameter int DRIP_SECS  = 2,
  parameter int MAX_CUPS   = 3,
  parameter int SLEEP_SECS = 30
) (
  input  logic               clk_100MHz,
  input  logic               reset_n,
  input  logic               tick_1Hz,
  input  logic               brew_btn,
  input  logic               fill_btn,
  output logic               heater_on,
  output logic               pump_on,
  output logic [STATE_W-1:0] state,
  output logic [CUP_W-1:0]   cup_count,
  output logic               busy,
  output logic               err_empty
);

  // An out-of-range build never starts a brew cycle.
  localparam bit CFG_OK = (HEAT_SECS  >= 1) && (HEAT_SECS  <= 15) &&
                          (PUMP_SECS  >= 1) && (PUMP_SECS  <= 15) &&
                          (DRIP_SECS  >= 1) && (DRIP_SECS  <= 15) &&
                          (MAX_CUPS   >= 1) && (MAX_CUPS   <= 3)  &&
                          (SLEEP_SECS >= 1) && (SLEEP_SECS <= 63);

  brew_state_t        state_q, state_nx;
  logic [CUP_W-1:0]   cup_q, cup_nx;
  logic               err_nx;
  logic               brew_d, fill_d;
  logic               brew_edge, fill_edge;
  logic               timer_clear, timer_done;
  logic [TIMER_W-1:0] timer_target;
  logic               sleep_hit;

  assign brew_edge = brew_btn && !brew_d;
  assign fill_edge = fill_btn && !fill_d;

  always_comb begin
    timer_target = TIMER_W'(HEAT_SECS);
    case (state_q)
      PUMP:    timer_target = TIMER_W'(PUMP_SECS);
      DRIP:    timer_target = TIMER_W'(DRIP_SECS);
      default: timer_target = TIMER_W'(HEAT_SECS);
    endcase
  end

  // Clearing on any state change makes every phase start from zero.
  assign timer_clear = (state_nx != state_q) || !is_busy(state_q);

  phase_timer u_phase_timer (
    .clk    (clk_100MHz),
    .rst_n  (reset_n),
    .clear  (timer_clear),
    .tick   (tick_1Hz),
    .target (timer_target),
    .done   (timer_done)
  );

`ifdef IDLE_SLEEP_EN
  logic [IDLE_W-1:0] idle_cnt;

  assign sleep_hit = (state_q == IDLE) && tick_1Hz &&
                     (idle_cnt == IDLE_W'(SLEEP_SECS - 1));

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt <= '0;
    end else if ((state_q != IDLE) || brew_edge || fill_edge) begin
      idle_cnt <= '0;
    end else if (tick_1Hz) begin
      idle_cnt <= idle_cnt + IDLE_W'(1);
    end
  end
`else
  assign sleep_hit = 1'b0;
`endif

  always_comb begin
    state_nx = state_q;
    cup_nx   = cup_q;
    err_nx   = 1'b0;
    case (state_q)
      IDLE: begin
        // Fill has priority; a brew edge in the same cycle is dropped.
        if (fill_edge) begin
          cup_nx = CUP_W'(MAX_CUPS);
        end else if (brew_edge) begin
          if (cup_q == '0) begin
            err_nx = 1'b1;
          end else if (CFG_OK) begin
            state_nx = HEAT;
          end
        end else if (sleep_hit) begin
          state_nx = SLEEP;
        end
      end
      HEAT: begin
        if (brew_edge) begin
          state_nx = IDLE;
        end else if (timer_done) begin
          state_nx = PUMP;
        end
      end
      PUMP: begin
        // The only place water is consumed; HEAT entry guarantees cup_q > 0.
        if (timer_done) begin
          state_nx = DRIP;
          cup_nx   = cup_q - CUP_W'(1);
        end
      end
      DRIP: begin
        if (timer_done) begin
          state_nx = IDLE;
        end
      end
      SLEEP: begin
`ifdef IDLE_SLEEP_EN
        // The wake edge is consumed: no fill or brew happens here.
        if (brew_edge || fill_edge) begin
          state_nx = IDLE;
        end
`else
        state_nx = IDLE;
`endif
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_100MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cup_q     <= '0;
      heater_on <= 1'b0;
      pump_on   <= 1'b0;
      busy      <= 1'b0;
      err_empty <= 1'b0;
      brew_d    <= 1'b0;
      fill_d    <= 1'b0;
    end else begin
      state_q   <= state_nx;
      cup_q     <= cup_nx;
      heater_on <= (state_nx == HEAT) || (state_nx == PUMP);
      pump_on   <= (state_nx == PUMP);
      busy      <= is_busy(state_nx);
      err_empty <= err_nx;
      brew_d    <= brew_btn;
      fill_d    <= fill_btn;
    end
  end

  assign state     = state_q;
  assign cup_count = cup_q;

endmodule

// File: tb/tb_brew_sequencer.sv
// tb_brew_sequencer: directed, table-driven bench for brew_sequencer with
// default phase lengths (3/5/2 ticks), MAX_CUPS=3 and SLEEP_SECS=4.
module tb_brew_sequencer;

  logic       clk_100MHz;
  logic       reset_n;
  logic       tick_1Hz;
  logic       brew_btn;
  logic       fill_btn;
  logic       heater_on;
  logic       pump_on;
  logic [2:0] state;
  logic [1:0] cup_count;
  logic       busy;
  logic       err_empty;

  int n_checks = 0;
  int n_errors = 0;

  brew_sequencer #(
    .HEAT_SECS  (3),
    .PUMP_SECS  (5),
    .DRIP_SECS  (2),
    .MAX_CUPS   (3),
    .SLEEP_SECS (4)
  ) dut (
    .clk_100MHz (clk_100MHz),
    .reset_n    (reset_n),
    .tick_1Hz   (tick_1Hz),
    .brew_btn   (brew_btn),
    .fill_btn   (fill_btn),
    .heater_on  (heater_on),
    .pump_on    (pump_on),
    .state      (state),
    .cup_count  (cup_count),
    .busy       (busy),
    .err_empty  (err_empty)
  );

  // ---------------- clock / reset ----------------
  initial clk_100MHz = 1'b0;
  always #5 clk_100MHz = ~clk_100MHz;

  initial begin
    #200us;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 ns after the clock edge.
  task automatic step(input logic t, input logic b, input logic f);
    tick_1Hz = t;
    brew_btn = b;
    fill_btn = f;
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic do_reset();
    reset_n  = 1'b0;
    tick_1Hz = 1'b0;
    brew_btn = 1'b0;
    fill_btn = 1'b0;
    repeat (2) @(posedge clk_100MHz);
    #1;
    reset_n = 1'b1;
    step(0, 0, 0);
  endtask

  // One brew: press (or hold) brew, tick every cycle until back in IDLE.
  task automatic brew_cycle(input logic hold, input logic [1:0] exp_cups, input string tag);
    int heat_n = 0;
    int pump_n = 0;
    step(0, 1, 0);
    check({tag, ".enter_heat"}, 32'(state), 32'd1);
    for (int k = 0; k < 60 && state != 3'd0; k++) begin
      if (heater_on) heat_n++;
      if (pump_on) pump_n++;
      step(1, hold, 0);
    end
    check({tag, ".back_idle"}, 32'(state), 32'd0);
    check({tag, ".heater_ticks"}, 32'(heat_n), 32'd8);
    check({tag, ".pump_ticks"}, 32'(pump_n), 32'd5);
    check({tag, ".cups"}, 32'(cup_count), 32'(exp_cups));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       tick;
    logic       brew;
    logic       fill;
    logic [2:0] st;
    logic       heat;
    logic       pump;
    logic [1:0] cups;
    logic       busy;
    logic       err;
  } vec_t;

  vec_t vt[21];

  initial begin
    //         tick brew fill | st heat pump cups busy err
    vt[0]  = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    vt[1]  = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1}; // empty brew
    vt[2]  = '{1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0}; // held: no repeat
    vt[3]  = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0}; // fill
    vt[5]  = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0};
    vt[6]  = '{1'b0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0}; // brew -> HEAT
    vt[7]  = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0}; // heat tick 1
    vt[8]  = '{1'b0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0};
    vt[9]  = '{1'b1, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 2'd3, 1'b1, 1'b0}; // heat tick 2
    vt[10] = '{1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0}; // heat tick 3 -> PUMP
    vt[11] = '{1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0};
    vt[12] = '{1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0};
    vt[13] = '{1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0};
    vt[14] = '{1'b1, 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, 2'd3, 1'b1, 1'b0};
    vt[15] = '{1'b1, 1'b0, 1'b0, 3'd3, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0}; // pump tick 5 -> DRIP
    vt[16] = '{1'b0, 1'b0, 1'b1, 3'd3, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0}; // fill ignored
    vt[17] = '{1'b1, 1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0}; // brew ignored
    vt[18] = '{1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0}; // drip tick 2 -> IDLE
    vt[19] = '{1'b0, 1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0}; // refill
    vt[20] = '{1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0};
  end

  // ---------------- test sequence ----------------
  initial begin
    reset_n  = 1'b0;
    tick_1Hz = 1'b0;
    brew_btn = 1'b0;
    fill_btn = 1'b0;
    #2;
    check("reset.state", 32'(state), 32'd0);
    check("reset.cups", 32'(cup_count), 32'd0);
    check("reset.heater", 32'(heater_on), 32'd0);
    check("reset.err", 32'(err_empty), 32'd0);

    // Table: empty brew, fill, full cycle, ignored buttons in DRIP.
    do_reset();
    for (int i = 0; i < 21; i++) begin
      step(vt[i].tick, vt[i].brew, vt[i].fill);
      check($sformatf("vec%0d.state", i), 32'(state), 32'(vt[i].st));
      check($sformatf("vec%0d.heater", i), 32'(heater_on), 32'(vt[i].heat));
      check($sformatf("vec%0d.pump", i), 32'(pump_on), 32'(vt[i].pump));
      check($sformatf("vec%0d.cups", i), 32'(cup_count), 32'(vt[i].cups));
      check($sformatf("vec%0d.busy", i), 32'(busy), 32'(vt[i].busy));
      check($sformatf("vec%0d.err", i), 32'(err_empty), 32'(vt[i].err));
    end

    // Drain and boundary: three brews, then a refused fourth with no wrap.
    do_reset();
    step(0, 0, 1);
    check("drain.fill", 32'(cup_count), 32'd3);
    step(0, 0, 0);
    brew_cycle(1'b0, 2'd2, "drain1");
    brew_cycle(1'b0, 2'd1, "drain2");
    brew_cycle(1'b0, 2'd0, "drain3");
    step(0, 0, 0);
    step(0, 1, 0);
    check("drain4.err", 32'(err_empty), 32'd1);
    check("drain4.state", 32'(state), 32'd0);
    step(0, 0, 0);
    check("drain4.err_one_cycle", 32'(err_empty), 32'd0);
    check("drain4.cups_no_wrap", 32'(cup_count), 32'd0);

    // Fill and brew on the same cycle with one cup left: fill wins.
    do_reset();
    step(0, 0, 1);
    step(0, 0, 0);
    brew_cycle(1'b0, 2'd2, "simul_a");
    brew_cycle(1'b0, 2'd1, "simul_b");
    step(0, 0, 0);
    step(0, 1, 1);
    check("simul.cups", 32'(cup_count), 32'd3);
    check("simul.state", 32'(state), 32'd0);
    check("simul.err", 32'(err_empty), 32'd0);
    step(0, 0, 0);
    check("simul.state_after", 32'(state), 32'd0);

    // Held brew across a whole cycle: exactly one brew.
    brew_cycle(1'b1, 2'd2, "held");
    step(1, 1, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    check("held.no_repeat_state", 32'(state), 32'd0);
    check("held.no_repeat_cups", 32'(cup_count), 32'd2);
    step(0, 0, 0);

    // Cancel during HEAT after one tick.
    step(0, 1, 0);
    check("cancel.heat", 32'(state), 32'd1);
    step(1, 0, 0);
    check("cancel.still_heat", 32'(state), 32'd1);
    step(0, 1, 0);
    check("cancel.state", 32'(state), 32'd0);
    check("cancel.cups", 32'(cup_count), 32'd2);
    check("cancel.heater", 32'(heater_on), 32'd0);
    check("cancel.busy", 32'(busy), 32'd0);
    step(0, 0, 0);

    // Asynchronous reset in PUMP, sampled before the next clock edge.
    step(0, 1, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    check("rst_pump.in_pump", 32'(state), 32'd2);
    reset_n = 1'b0;
    #1;
    check("rst_pump.state", 32'(state), 32'd0);
    check("rst_pump.heater", 32'(heater_on), 32'd0);
    check("rst_pump.pump", 32'(pump_on), 32'd0);
    check("rst_pump.busy", 32'(busy), 32'd0);
    check("rst_pump.cups", 32'(cup_count), 32'd0);
    check("rst_pump.err", 32'(err_empty), 32'd0);
    @(posedge clk_100MHz);
    #1;
    reset_n = 1'b1;
    step(0, 0, 0);

`ifdef IDLE_SLEEP_EN
    // Four idle ticks put the block to sleep; the wake fill is consumed.
    do_reset();
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    check("sleep.not_yet", 32'(state), 32'd0);
    step(1, 0, 0);
    check("sleep.state", 32'(state), 32'd4);
    check("sleep.heater", 32'(heater_on), 32'd0);
    check("sleep.busy", 32'(busy), 32'd0);
    step(0, 0, 1);
    check("wake.state", 32'(state), 32'd0);
    check("wake.cups", 32'(cup_count), 32'd0);
    step(0, 0, 0);
    step(0, 0, 1);
    check("wake.fill_cups", 32'(cup_count), 32'd3);
    check("wake.fill_state", 32'(state), 32'd0);
    step(0, 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
